// File: rtl/rw_pkg.sv
// Shared constants, field ranges and state type for the register-writeback stage.
package rw_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = $clog2(NREGS);

    // Instruction field ranges
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 22;

    localparam logic [AW-1:0]    RA_IDX  = AW'(15);
    localparam logic [OPC_W-1:0] END_OPC = 5'b11111;

    typedef enum logic {
        RW_RUN,
        RW_HALTED
    } rw_state_t;

endpackage

// File: rtl/rw_regfile.sv
// 16 x 32 register file: one write port, two combinational read ports.
// Optional same-cycle write-through on reads when RW_BYPASS_EN is defined.
module rw_regfile
    import rw_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs_q [NREGS];

    // Storage: cleared asynchronously, written on the rising edge when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

`ifdef RW_BYPASS_EN
    // Read ports forward the value being written this cycle
    assign rdata1 = (we && (raddr1 == waddr)) ? wdata : regs_q[raddr1];
    assign rdata2 = (we && (raddr2 == waddr)) ? wdata : regs_q[raddr2];
`else
    // Read ports return stored contents only; writer must be followed by a stall
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
`endif

endmodule

// File: rtl/rw_stage.sv
// Register-writeback stage: result select, register-file commit,
// retirement counting and halt tracking. Optional macro: RW_BYPASS_EN.
module rw_stage
    import rw_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MA_RW_valid,
    input  logic [DW-1:0] MA_RW_aluresult,
    input  logic [DW-1:0] Ldresult,
    input  logic [DW-1:0] MA_RW_inst,
    input  logic [DW-1:0] MA_RW_pc,
    input  logic          isWb_MR,
    input  logic          isLd_MR,
    input  logic          isCall_MR,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          halted,
    output logic [DW-1:0] retired_count
);

    rw_state_t     state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          is_end_c;
    logic          unused_inst_c;

    assign is_end_c      = (MA_RW_inst[OPC_MSB:OPC_LSB] == END_OPC);
    assign unused_inst_c = ^{MA_RW_inst[26], MA_RW_inst[RD_LSB-1:0]};

    // Result and destination select: call > load > ALU
    always_comb begin
        wb_data = MA_RW_aluresult;
        wb_addr = MA_RW_inst[RD_MSB:RD_LSB];
        if (isCall_MR) begin
            wb_data = MA_RW_pc + DW'(4);
            wb_addr = RA_IDX;
        end else if (isLd_MR) begin
            wb_data = Ldresult;
        end
    end

    // Write strobe; held low during reset and once halted
    assign wb_en = rst_n & MA_RW_valid & (isWb_MR | isCall_MR) & (state_q == RW_RUN);

    // State and retirement counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RW_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: retire valid instructions in RUN, saturate counter, halt on end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if ((state_q == RW_RUN) && MA_RW_valid) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + DW'(1);
            end
            if (is_end_c) begin
                state_d = RW_HALTED;
            end
        end
    end

    assign halted        = (state_q == RW_HALTED);
    assign retired_count = cnt_q;

    rw_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rd_addr1),
        .raddr2 (rd_addr2),
        .rdata1 (rd_data1),
        .rdata2 (rd_data2)
    );

endmodule

// File: tb/tb_rw_stage.sv
// Self-checking bench for rw_stage: directed scenarios plus randomized traffic
// compared against a register-array reference model.
module tb_rw_stage;

    logic        clk;
    logic        rst_n;
    logic        MA_RW_valid;
    logic [31:0] MA_RW_aluresult;
    logic [31:0] Ldresult;
    logic [31:0] MA_RW_inst;
    logic [31:0] MA_RW_pc;
    logic        isWb_MR;
    logic        isLd_MR;
    logic        isCall_MR;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic [31:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_regs [16];
    logic [31:0] m_cnt;
    logic        m_halt;

    rw_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MA_RW_valid     (MA_RW_valid),
        .MA_RW_aluresult (MA_RW_aluresult),
        .Ldresult        (Ldresult),
        .MA_RW_inst      (MA_RW_inst),
        .MA_RW_pc        (MA_RW_pc),
        .isWb_MR         (isWb_MR),
        .isLd_MR         (isLd_MR),
        .isCall_MR       (isCall_MR),
        .rd_addr1        (rd_addr1),
        .rd_addr2        (rd_addr2),
        .rd_data1        (rd_data1),
        .rd_data2        (rd_data2),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .halted          (halted),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_cnt  = 32'h0;
        m_halt = 1'b0;
    endtask

    function automatic logic [31:0] mk_inst(input logic [4:0] opc, input logic [3:0] rd);
        logic [31:0] w;
        w = $urandom;
        w[31:27] = opc;
        w[25:22] = rd;
        return w;
    endfunction

    // One pipeline cycle: drive at negedge, check combinational outputs, clock, check state
    task automatic step(input logic v, input logic wb, input logic ld, input logic call,
                        input logic [31:0] alu, input logic [31:0] ldr,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic [3:0] ra1, input logic [3:0] ra2);
        logic        e_we;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_rd1, e_rd2;
        @(negedge clk);
        MA_RW_valid = v; isWb_MR = wb; isLd_MR = ld; isCall_MR = call;
        MA_RW_aluresult = alu; Ldresult = ldr; MA_RW_inst = inst; MA_RW_pc = pc;
        rd_addr1 = ra1; rd_addr2 = ra2;
        e_addr = call ? 4'd15 : inst[25:22];
        e_data = call ? (pc + 32'd4) : (ld ? ldr : alu);
        e_we   = v && (wb || call) && !m_halt;
        e_rd1  = m_regs[ra1];
        e_rd2  = m_regs[ra2];
`ifdef RW_BYPASS_EN
        if (e_we && ra1 == e_addr) e_rd1 = e_data;
        if (e_we && ra2 == e_addr) e_rd2 = e_data;
`endif
        #1;
        chk("wb_en", 32'(wb_en), 32'(e_we));
        if (e_we) begin
            chk("wb_addr", 32'(wb_addr), 32'(e_addr));
            chk("wb_data", wb_data, e_data);
        end
        chk("rd_data1", rd_data1, e_rd1);
        chk("rd_data2", rd_data2, e_rd2);
        @(posedge clk);
        if (!m_halt && v) begin
            if (wb || call) m_regs[e_addr] = e_data;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (inst[31:27] == 5'h1F) m_halt = 1'b1;
        end
        #1;
        chk("halted", 32'(halted), 32'(m_halt));
        chk("retired_count", retired_count, m_cnt);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        MA_RW_valid = 1'b0;
        rd_addr1 = a;
        #1;
        chk(tag, rd_data1, exp);
    endtask

    initial begin
        logic [31:0] inst;
        logic        pre_ok;
        rst_n = 1'b0;
        MA_RW_valid = 1'b0; isWb_MR = 1'b0; isLd_MR = 1'b0; isCall_MR = 1'b0;
        MA_RW_aluresult = '0; Ldresult = '0; MA_RW_inst = '0; MA_RW_pc = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        model_reset();
        #12;
        chk("reset_halted", 32'(halted), 32'h0);
        chk("reset_count", retired_count, 32'h0);
        chk("reset_wb_en", 32'(wb_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write to r3
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, mk_inst(5'h01, 4'd3), 32'h40, 4'd3, 4'd0);
        read_check("alu_r3", 4'd3, 32'h1234_5678);
        chk("alu_count", retired_count, 32'd1);

        // Load has priority over ALU
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'hDEAD_BEEF, mk_inst(5'h02, 4'd5), 32'h44, 4'd0, 4'd0);
        read_check("load_r5", 4'd5, 32'hDEAD_BEEF);

        // Call writes return address to r15, leaves rd field register alone
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'h88, mk_inst(5'h03, 4'd2), 32'h0000_0100, 4'd0, 4'd0);
        read_check("call_r15", 4'd15, 32'h0000_0104);
        read_check("call_r2", 4'd2, 32'h0);

        // Same-cycle read of register being written
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0, mk_inst(5'h04, 4'd7), 32'h48, 4'd0, 4'd7);
        read_check("samecyc_r7", 4'd7, 32'hA5A5_A5A5);

        // Non-writing instruction still retires
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0, mk_inst(5'h05, 4'd9), 32'h4C, 4'd9, 4'd9);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            inst = $urandom;
            if (inst[31:27] == 5'h1F) inst[27] = 1'b0;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), $urandom, $urandom, inst, $urandom,
                 4'($urandom), 4'($urandom));
        end

        // Halt: end retires, later write is suppressed
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, mk_inst(5'h1F, 4'd0), 32'h200, 4'd1, 4'd1);
        chk("halt_flag", 32'(halted), 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h9, 32'h0, mk_inst(5'h01, 4'd1), 32'h204, 4'd1, 4'd1);
        read_check("halt_r1", 4'd1, m_regs[1]);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h9, 32'h0, mk_inst(5'h01, 4'd1), 32'h208, 4'd15, 4'd1);

        // Async reset mid-cycle while a write is presented
        @(negedge clk);
        MA_RW_valid = 1'b1; isWb_MR = 1'b1; isLd_MR = 1'b0; isCall_MR = 1'b0;
        MA_RW_aluresult = 32'hCAFE_F00D; MA_RW_inst = mk_inst(5'h01, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wb_en", 32'(wb_en), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_count", retired_count, 32'h0);
        pre_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            #1;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) pre_ok = 1'b0;
        end
        chk("rst_all_regs_zero", 32'(pre_ok), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        MA_RW_valid = 1'b0;
        read_check("rst_r4", 4'd4, 32'h0);

        // Counter saturation
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0, mk_inst(5'h01, 4'd6), 32'h0, 4'd6, 4'd0);
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, mk_inst(5'h01, 4'd0), 32'h0, 4'd0, 4'd0);
        @(negedge clk);
        release dut.cnt_q;
        #1;
        chk("sat_after_release", retired_count, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 32'h0, mk_inst(5'h01, 4'd8), 32'h0, 4'd8, 4'd0);
        chk("sat_hold", retired_count, 32'hFFFF_FFFF);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
